// File: rtl/spram_pkg.sv
// Shared constants and bank power-state encoding for the banked SPRAM data memory.
package spram_pkg;

  localparam int SPRAM_WORDS = 16384;
  localparam int SPRAM_AW    = 14;
  localparam int BE_W        = 4;
  localparam int IDLE_CNT_W  = 10;
  localparam int WAKE_CNT_W  = 4;

  typedef logic [1:0] bank_state_t;

  localparam bank_state_t BANK_AWAKE  = 2'd0;
  localparam bank_state_t BANK_SLEEP  = 2'd1;
  localparam bank_state_t BANK_WAKING = 2'd2;

  // One byte enable covers two nibbles of a 16-bit SPRAM word.
  function automatic logic [3:0] nibble_mask(input logic [1:0] be_pair);
    return {be_pair[1], be_pair[1], be_pair[0], be_pair[0]};
  endfunction

endpackage

// File: rtl/spram_banked_mem_if.sv
// Request/response bus between the load/store unit (master) and the banked SPRAM memory (slave).
interface spram_banked_mem_if #(parameter int ADDR_W = 15) ();
  import spram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port RAM with nibble write masks.
// Output holds its last read value; writes leave DATAOUT unchanged.
module SB_SPRAM256KA
  import spram_pkg::*;
(
  input  logic [SPRAM_AW-1:0] ADDRESS,
  input  logic [15:0]         DATAIN,
  input  logic [3:0]          MASKWREN,
  input  logic                WREN,
  input  logic                CHIPSELECT,
  input  logic                CLOCK,
  input  logic                STANDBY,
  input  logic                SLEEP,
  input  logic                POWEROFF,
  output logic [15:0]         DATAOUT
);

  logic [15:0] mem [SPRAM_WORDS];
  logic [15:0] merged;
  logic [15:0] dataout_d, dataout_q;
  logic        enable;

  assign enable  = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;
  assign DATAOUT = dataout_q;

  always_comb begin
    merged = mem[ADDRESS];
    for (int n = 0; n < 4; n++) begin
      if (MASKWREN[n]) merged[4*n +: 4] = DATAIN[4*n +: 4];
    end
    dataout_d = (enable && !WREN) ? mem[ADDRESS] : dataout_q;
  end

  always_ff @(posedge CLOCK) begin
    dataout_q <= dataout_d;
    if (enable && WREN) mem[ADDRESS] <= merged;
  end

endmodule

// File: rtl/spram_bank_pm.sv
// One 16K x 32 bank (two SPRAMs in width cascade) with its own idle-timeout sleep/wake controller.
module spram_bank_pm
  import spram_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwr_en,
  input  logic                sel,
  input  logic                we,
  input  logic [SPRAM_AW-1:0] addr,
  input  logic [31:0]         wdata,
  input  logic [BE_W-1:0]     be,
  output logic                awake,
  output logic [31:0]         rdata
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_MAX = WAKE_CNT_W'(WAKE_CYCLES - 1);

  bank_state_t           state_d, state_q;
  logic [IDLE_CNT_W-1:0] idle_cnt_d, idle_cnt_q;
  logic [WAKE_CNT_W-1:0] wake_cnt_d, wake_cnt_q;
  logic                  access;
  logic                  wren;
  logic                  sleep_pin;
  logic [3:0]            mask_hi, mask_lo;

  assign awake     = (state_q == BANK_AWAKE);
  assign access    = sel && awake;
  assign wren      = access && we;
  assign sleep_pin = (state_q == BANK_SLEEP);
  assign mask_hi   = nibble_mask(be[3:2]);
  assign mask_lo   = nibble_mask(be[1:0]);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      BANK_AWAKE: begin
        // An access in the expiry cycle wins over the timeout.
        if (access) begin
          idle_cnt_d = '0;
        end else if (pwr_en && idle_cnt_q == IDLE_MAX) begin
          state_d = BANK_SLEEP;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      BANK_SLEEP: begin
        if (sel || !pwr_en) begin
          state_d    = BANK_WAKING;
          wake_cnt_d = '0;
        end
      end
      BANK_WAKING: begin
        if (wake_cnt_q == WAKE_MAX) begin
          state_d    = BANK_AWAKE;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = BANK_AWAKE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BANK_AWAKE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  SB_SPRAM256KA u_spram_hi (
    .ADDRESS    (addr),
    .DATAIN     (wdata[31:16]),
    .MASKWREN   (mask_hi),
    .WREN       (wren),
    .CHIPSELECT (access),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (sleep_pin),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata[31:16])
  );

  SB_SPRAM256KA u_spram_lo (
    .ADDRESS    (addr),
    .DATAIN     (wdata[15:0]),
    .MASKWREN   (mask_lo),
    .WREN       (wren),
    .CHIPSELECT (access),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (sleep_pin),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata[15:0])
  );

endmodule

// File: rtl/spram_banked_mem.sv
// 32-bit data memory of NUM_BANKS depth-cascaded SPRAM banks with byte enables,
// valid/ready requests, a registered read response and per-bank auto sleep.
module spram_banked_mem
  import spram_pkg::*;
#(
  parameter int NUM_BANKS    = 2,
  parameter int IDLE_TIMEOUT = 64,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwr_en,
  spram_banked_mem_if.slave    bus,
  output logic [NUM_BANKS-1:0] bank_asleep
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BIDX_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int ADDR_W = SPRAM_AW + BANK_W;

  logic [BIDX_W-1:0]    req_bank;
  logic [NUM_BANKS-1:0] bank_sel;
  logic [NUM_BANKS-1:0] bank_awake;
  logic [31:0]          bank_rdata [NUM_BANKS];
  logic                 req_ready;
  logic                 rd_accept;
  logic [31:0]          rsp_rdata;
  logic                 rsp_valid_d, rsp_valid_q;
  logic [BIDX_W-1:0]    rsp_bank_d, rsp_bank_q;
  logic [31:0]          rdata_hold_d, rdata_hold_q;

  if (NUM_BANKS == 1) begin : g_one_bank
    assign req_bank = '0;
  end else begin : g_multi_bank
    assign req_bank = bus.req_addr[ADDR_W-1:SPRAM_AW];
  end

  always_comb begin
    bank_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = bus.req_valid && (req_bank == BIDX_W'(b));
    end
  end

  assign req_ready     = bank_awake[req_bank];
  assign bus.req_ready = req_ready;
  assign rd_accept     = bus.req_valid && req_ready && !bus.req_we;
  assign bank_asleep   = ~bank_awake;

  // The SPRAM output is live only in the response cycle; afterwards the held copy is shown.
  assign rsp_rdata     = rsp_valid_q ? bank_rdata[rsp_bank_q] : rdata_hold_q;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_valid = rsp_valid_q;

  always_comb begin
    rsp_valid_d  = rd_accept;
    rsp_bank_d   = rd_accept ? req_bank : rsp_bank_q;
    rdata_hold_d = rsp_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_bank_q   <= '0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_bank_q   <= rsp_bank_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spram_bank_pm #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .WAKE_CYCLES  (WAKE_CYCLES)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .pwr_en (pwr_en),
      .sel    (bank_sel[b]),
      .we     (bus.req_we),
      .addr   (bus.req_addr[SPRAM_AW-1:0]),
      .wdata  (bus.req_wdata),
      .be     (bus.req_be),
      .awake  (bank_awake[b]),
      .rdata  (bank_rdata[b])
    );
  end

endmodule
